// File: rtl/ncpu32k_bru_wb_pkg.sv
// Shared types for the branch resolution / writeback unit: PC width, queue record, FSM states.
package ncpu32k_bru_wb_pkg;

  localparam int unsigned NCPU_AW = 32;
  localparam int unsigned PC_W    = NCPU_AW - 2;

  typedef logic [PC_W-1:0] pc_t;

  // One in-flight predicted control-flow instruction
  typedef struct packed {
    pc_t  pc;
    logic pred_taken;
    pc_t  pred_tgt;
  } br_rec_t;

  localparam int unsigned REC_W = $bits(br_rec_t);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } bru_state_e;

  // Fall-through word PC, wrapping at 2**PC_W
  function automatic pc_t pc_next(input pc_t pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/ncpu32k_bru_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers and a synchronous clear.
module ncpu32k_bru_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout_c,
  output logic          full_c,
  output logic          empty_c
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   w_ptr;
  logic [AW:0]   r_ptr;

  // Pointer update; clear wins over any push/pop in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else if (clr) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (push) w_ptr <= w_ptr + (AW+1)'(1);
      if (pop)  r_ptr <= r_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[w_ptr[AW-1:0]] <= din;
  end

  assign dout_c  = mem[r_ptr[AW-1:0]];
  assign empty_c = (w_ptr == r_ptr);
  assign full_c  = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);

endmodule

// File: rtl/ncpu32k_bru_wb.sv
// Branch resolution and writeback: checks in-order outcomes against predictions, redirects and trains the BPU.
// Optional perf counters enabled by defining NCPU_BRU_PERF_CNT_EN.
module ncpu32k_bru_wb
  import ncpu32k_bru_wb_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_valid,
  output logic            push_ready,
  input  logic [PC_W-1:0] push_pc,
  input  logic            push_pred_taken,
  input  logic [PC_W-1:0] push_pred_tgt,
  input  logic            rsv_valid,
  output logic            rsv_ready,
  input  logic            rsv_taken,
  input  logic [PC_W-1:0] rsv_tgt,
  input  logic            flush_all,
  output logic            flush_req,
  output logic [PC_W-1:0] flush_tgt,
  output logic            bpu_wb,
  output logic [PC_W-1:0] bpu_wb_insn_pc,
  output logic            bpu_wb_taken,
  output logic [PC_W-1:0] bpu_wb_tgt,
  output logic            q_empty
`ifdef NCPU_BRU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_br_cnt,
  output logic [31:0]     perf_mis_cnt
`endif
);

  bru_state_e state;
  br_rec_t    push_rec;
  br_rec_t    head_c;
  logic       full_c;
  logic       empty_c;
  logic       push_fire_c;
  logic       rsv_fire_c;
  logic       mispred_c;
  logic       fifo_clr_c;

  assign push_rec    = '{pc: push_pc, pred_taken: push_pred_taken, pred_tgt: push_pred_tgt};
  assign push_ready  = (state == ST_RUN) && !full_c;
  assign rsv_ready   = (state == ST_RUN) && !empty_c;
  assign push_fire_c = push_valid && push_ready;
  assign rsv_fire_c  = rsv_valid && rsv_ready;
  assign mispred_c   = (head_c.pred_taken != rsv_taken) ||
                       (rsv_taken && (head_c.pred_tgt != rsv_tgt));
  // A mispredict squashes everything younger, including a same-cycle push
  assign fifo_clr_c  = flush_all || (rsv_fire_c && mispred_c);
  assign q_empty     = empty_c;

  ncpu32k_bru_fifo #(
    .DW (REC_W),
    .AW (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (fifo_clr_c),
    .push    (push_fire_c),
    .pop     (rsv_fire_c),
    .din     (push_rec),
    .dout_c  (head_c),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  // Redirect FSM and training outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_RUN;
      flush_req      <= 1'b0;
      flush_tgt      <= '0;
      bpu_wb         <= 1'b0;
      bpu_wb_insn_pc <= '0;
      bpu_wb_taken   <= 1'b0;
      bpu_wb_tgt     <= '0;
    end else begin
      bpu_wb    <= rsv_fire_c;
      flush_req <= 1'b0;
      if (rsv_fire_c) begin
        bpu_wb_insn_pc <= head_c.pc;
        bpu_wb_taken   <= rsv_taken;
        bpu_wb_tgt     <= rsv_tgt;
      end
      if (flush_all) begin
        state <= ST_RUN;
      end else begin
        case (state)
          ST_RUN: begin
            if (rsv_fire_c && mispred_c) begin
              state     <= ST_FLUSH;
              flush_req <= 1'b1;
              flush_tgt <= rsv_taken ? rsv_tgt : pc_next(head_c.pc);
            end
          end
          default: state <= ST_RUN;
        endcase
      end
    end
  end

`ifdef NCPU_BRU_PERF_CNT_EN
  // Saturating branch / mispredict counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_cnt  <= '0;
      perf_mis_cnt <= '0;
    end else if (rsv_fire_c) begin
      if (perf_br_cnt != 32'hFFFF_FFFF) perf_br_cnt <= perf_br_cnt + 32'd1;
      if (mispred_c && (perf_mis_cnt != 32'hFFFF_FFFF)) perf_mis_cnt <= perf_mis_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ncpu32k_bru_wb.sv
// Self-checking bench for ncpu32k_bru_wb: directed test-plan steps, then random traffic against a queue model.
module tb_ncpu32k_bru_wb;
  import ncpu32k_bru_wb_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      push_valid = 1'b0;
  logic      push_ready;
  pc_t       push_pc = '0;
  logic      push_pred_taken = 1'b0;
  pc_t       push_pred_tgt = '0;
  logic      rsv_valid = 1'b0;
  logic      rsv_ready;
  logic      rsv_taken = 1'b0;
  pc_t       rsv_tgt = '0;
  logic      flush_all = 1'b0;
  logic      flush_req;
  pc_t       flush_tgt;
  logic      bpu_wb;
  pc_t       bpu_wb_insn_pc;
  logic      bpu_wb_taken;
  pc_t       bpu_wb_tgt;
  logic      q_empty;
`ifdef NCPU_BRU_PERF_CNT_EN
  logic [31:0] perf_br_cnt;
  logic [31:0] perf_mis_cnt;
`endif

  ncpu32k_bru_wb #(.DEPTH_LOG2(2)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
    .push_pred_taken(push_pred_taken), .push_pred_tgt(push_pred_tgt),
    .rsv_valid(rsv_valid), .rsv_ready(rsv_ready), .rsv_taken(rsv_taken), .rsv_tgt(rsv_tgt),
    .flush_all(flush_all), .flush_req(flush_req), .flush_tgt(flush_tgt),
    .bpu_wb(bpu_wb), .bpu_wb_insn_pc(bpu_wb_insn_pc), .bpu_wb_taken(bpu_wb_taken),
    .bpu_wb_tgt(bpu_wb_tgt), .q_empty(q_empty)
`ifdef NCPU_BRU_PERF_CNT_EN
    , .perf_br_cnt(perf_br_cnt), .perf_mis_cnt(perf_mis_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  br_rec_t q[$];
  logic    m_flush = 1'b0;
  logic    e_wb = 1'b0, e_wb_taken = 1'b0, e_fr = 1'b0;
  pc_t     e_wb_pc = '0, e_wb_tgt = '0, e_ftgt = '0;
  longint  m_br = 0, m_mis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_flush = 1'b0; e_wb = 1'b0; e_wb_taken = 1'b0; e_fr = 1'b0;
    e_wb_pc = '0; e_wb_tgt = '0; e_ftgt = '0;
    m_br = 0; m_mis = 0;
  endtask

  // One clock: drive at negedge, check handshakes, advance model, check registered outputs at next negedge
  task automatic cycle(input logic pv, input pc_t ppc, input logic ppt, input pc_t ptgt,
                       input logic rv, input logic rt, input pc_t rtgt, input logic fa);
    logic    exp_pr, exp_rr, pf, rf, mis;
    br_rec_t e;
    push_valid = pv; push_pc = ppc; push_pred_taken = ppt; push_pred_tgt = ptgt;
    rsv_valid = rv; rsv_taken = rt; rsv_tgt = rtgt; flush_all = fa;
    #1;
    exp_pr = !m_flush && (q.size() < DEPTH);
    exp_rr = !m_flush && (q.size() != 0);
    check("push_ready", 64'(push_ready), 64'(exp_pr));
    check("rsv_ready", 64'(rsv_ready), 64'(exp_rr));
    pf = pv && exp_pr;
    rf = rv && exp_rr;
    mis = 1'b0;
    e = '0;
    e_wb = rf;
    if (rf) begin
      e = q.pop_front();
      mis = (e.pred_taken != rt) || (rt && (e.pred_tgt != rtgt));
      e_wb_pc = e.pc; e_wb_taken = rt; e_wb_tgt = rtgt;
      m_br++;
      if (mis) m_mis++;
    end
    if (pf) q.push_back('{pc: ppc, pred_taken: ppt, pred_tgt: ptgt});
    if (fa) begin
      q.delete(); m_flush = 1'b0; e_fr = 1'b0;
    end else if (rf && mis) begin
      q.delete(); m_flush = 1'b1; e_fr = 1'b1;
      e_ftgt = rt ? rtgt : PC_W'(e.pc + 30'd1);
    end else begin
      m_flush = 1'b0; e_fr = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("bpu_wb", 64'(bpu_wb), 64'(e_wb));
    check("bpu_wb_insn_pc", 64'(bpu_wb_insn_pc), 64'(e_wb_pc));
    check("bpu_wb_taken", 64'(bpu_wb_taken), 64'(e_wb_taken));
    check("bpu_wb_tgt", 64'(bpu_wb_tgt), 64'(e_wb_tgt));
    check("flush_req", 64'(flush_req), 64'(e_fr));
    check("flush_tgt", 64'(flush_tgt), 64'(e_ftgt));
    check("q_empty", 64'(q_empty), 64'(q.size() == 0));
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic push(input pc_t pc, input logic pt, input pc_t tgt);
    cycle(1'b1, pc, pt, tgt, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic resolve(input logic rt, input pc_t tgt);
    cycle(1'b0, '0, 1'b0, '0, 1'b1, rt, tgt, 1'b0);
  endtask

  initial begin
    #1;
    check("rst_push_ready", 64'(push_ready), 64'd1);
    check("rst_rsv_ready", 64'(rsv_ready), 64'd0);
    check("rst_q_empty", 64'(q_empty), 64'd1);
    check("rst_bpu_wb", 64'(bpu_wb), 64'd0);
    check("rst_flush_req", 64'(flush_req), 64'd0);
    check("rst_flush_tgt", 64'(flush_tgt), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Correct not-taken prediction
    push(30'h100, 1'b0, 30'h0);
    resolve(1'b0, 30'h0);
    check("t1_wb", 64'(bpu_wb), 64'd1);
    check("t1_pc", 64'(bpu_wb_insn_pc), 64'h100);
    check("t1_fr", 64'(flush_req), 64'd0);

    // Target mispredict
    push(30'h200, 1'b1, 30'h300);
    resolve(1'b1, 30'h340);
    check("t2_fr", 64'(flush_req), 64'd1);
    check("t2_ftgt", 64'(flush_tgt), 64'h340);
    check("t2_push_ready", 64'(push_ready), 64'd0);
    idle();
    check("t2_empty", 64'(q_empty), 64'd1);

    // Direction mispredict: fall-through, including PC wrap
    push(30'h400, 1'b1, 30'h500);
    resolve(1'b0, 30'h0);
    check("t3_ftgt", 64'(flush_tgt), 64'h401);
    idle();
    push(30'h3FFF_FFFF, 1'b1, 30'h10);
    resolve(1'b0, 30'h0);
    check("t3_wrap_ftgt", 64'(flush_tgt), 64'h0);
    idle();

    // Fill, push+resolve while full, drain in order
    for (int i = 0; i < 4; i++) push(PC_W'(30'h800 + 30'(i)), 1'b0, '0);
    check("t4_full", 64'(push_ready), 64'd0);
    cycle(1'b1, 30'h900, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    check("t4_pc0", 64'(bpu_wb_insn_pc), 64'h800);
    for (int i = 1; i < 4; i++) begin
      resolve(1'b0, '0);
      check("t4_order", 64'(bpu_wb_insn_pc), 64'(30'h800 + 30'(i)));
    end
    check("t4_drained", 64'(q_empty), 64'd1);

    // No empty bypass
    cycle(1'b1, 30'hA00, 1'b1, 30'hA80, 1'b1, 1'b1, 30'hA80, 1'b0);
    check("t5_no_wb", 64'(bpu_wb), 64'd0);
    resolve(1'b1, 30'hA80);
    check("t5_wb_pc", 64'(bpu_wb_insn_pc), 64'hA00);

    // flush_all with a correct resolve
    for (int i = 0; i < 3; i++) push(PC_W'(30'hB00 + 30'(i)), 1'b0, '0);
    cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    check("t6_wb", 64'(bpu_wb), 64'd1);
    check("t6_empty", 64'(q_empty), 64'd1);
    check("t6_fr", 64'(flush_req), 64'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic rt;
      pc_t  rtgt;
      rt = 1'($urandom);
      rtgt = PC_W'($urandom_range(0, 7));
      if (q.size() != 0) begin
        rt   = ($urandom_range(0, 4) == 0) ? !q[0].pred_taken : q[0].pred_taken;
        rtgt = ($urandom_range(0, 4) == 0) ? PC_W'($urandom) : q[0].pred_tgt;
      end
      cycle(1'($urandom_range(0, 2) != 0), PC_W'($urandom), 1'($urandom), PC_W'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), rt, rtgt, ($urandom_range(0, 29) == 0));
    end

`ifdef NCPU_BRU_PERF_CNT_EN
    check("perf_br", 64'(perf_br_cnt), 64'(m_br));
    check("perf_mis", 64'(perf_mis_cnt), 64'(m_mis));
`endif

    // Asynchronous reset mid-stream
    idle();
    push(30'hC00, 1'b0, '0);
    push(30'hC01, 1'b0, '0);
    resolve(1'b0, '0);
    check("t7_pre_wb", 64'(bpu_wb), 64'd1);
    rst = 1'b1;
    #1;
    check("t7_rst_empty", 64'(q_empty), 64'd1);
    check("t7_rst_wb", 64'(bpu_wb), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle();
    push(30'hD00, 1'b0, '0);
    resolve(1'b0, '0);
    check("t7_after_pc", 64'(bpu_wb_insn_pc), 64'hD00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ncpu32k_bru_wb.md
Name: ncpu32k_bru_wb

Overview:
- Branch resolution and writeback unit. It is the writeback-side partner of the branch predictor (ncpu32k_bpu).
- Fetch pushes each predicted control-flow instruction into an in-order record queue. Execute resolves branches in program order.
- On each resolve, the block compares actual against predicted, raises a one-cycle pipeline redirect on mispredict, and drives the predictor's bpu_wb* training interface.

Parameters:
- DEPTH_LOG2, 2, log2 of the in-flight prediction queue depth (queue depth = 2**DEPTH_LOG2 entries).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- push_valid  in  1  fetch presents a predicted branch record
- push_ready  out  1  queue can accept the record
- push_pc  in  NCPU_AW-2  word PC of the branch
- push_pred_taken  in  1  predictor's taken decision
- push_pred_tgt  in  NCPU_AW-2  predictor's target
- rsv_valid  in  1  execute presents the outcome of the oldest branch
- rsv_ready  out  1  outcome accepted
- rsv_taken  in  1  actual direction
- rsv_tgt  in  NCPU_AW-2  actual target
- flush_all  in  1  exception/interrupt squash
- flush_req  out  1  redirect pulse to fetch
- flush_tgt  out  NCPU_AW-2  redirect word PC
- bpu_wb  out  1  training strobe to the predictor
- bpu_wb_insn_pc  out  NCPU_AW-2  trained PC
- bpu_wb_taken  out  1  actual direction
- bpu_wb_tgt  out  NCPU_AW-2  actual target
- q_empty  out  1  no branch in flight

Behaviour:
- Reset: all outputs 0 except push_ready, which is 1. q_empty is 1. Queue pointers are 0. FSM is in RUN.
- Queue: circular buffer with 2**DEPTH_LOG2 entries. Read and write pointers are DEPTH_LOG2+1 bits wide; the MSB is the wrap bit.
  - full: pointers differ only in the MSB.
  - empty: pointers are equal.
- push_ready = RUN & !full. It does not depend on resolve in the same cycle, so there is no full-bypass.
- rsv_ready = RUN & !empty. There is no empty-bypass: a push and a resolve in the same cycle on an empty queue leaves the resolve unaccepted.
- A push and a resolve accepted in the same cycle update both pointers; the entry count is unchanged.
- Mispredict on an accepted resolve is (pred_taken != rsv_taken) | (rsv_taken & pred_tgt != rsv_tgt).
- Training: on every accepted resolve, the cycle after acceptance has:
  - bpu_wb = 1 for exactly one cycle;
  - bpu_wb_insn_pc = entry PC;
  - bpu_wb_taken = rsv_taken;
  - bpu_wb_tgt = rsv_tgt.
  - Otherwise bpu_wb = 0 and the data outputs hold their last value.
- FSM states: RUN, FLUSH.
  - RUN -> FLUSH on an accepted resolve with mispredict. Both pointers are reset to 0 at that edge.
  - A push offered in the same cycle as the mispredicting resolve is dropped: push_ready is still 1 that cycle, but the write is discarded by the pointer clear.
  - FLUSH: flush_req = 1, push_ready = 0, rsv_ready = 0. flush_tgt = rsv_taken ? rsv_tgt : entry PC + 1, modulo 2**(NCPU_AW-2). Always returns to RUN after 1 cycle.
- flush_all: synchronous squash. At the next edge both pointers go to 0. flush_req is not asserted (the exception unit redirects fetch). The FSM goes to RUN.
  - A resolve accepted in the same cycle still produces its bpu_wb pulse.
  - flush_all has priority over the mispredict FSM transition.
- Asynchronous rst mid-operation discards all in-flight records immediately.

Optional Feature:
- Macro NCPU_BRU_PERF_CNT_EN.
- When defined: adds outputs perf_br_cnt [31:0] and perf_mis_cnt [31:0].
  - perf_br_cnt increments on each accepted resolve; perf_mis_cnt increments on each mispredict.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package/config header holds:
  - the PC width NCPU_AW-2;
  - the queue record layout {pc, pred_taken, pred_tgt}, 1+2*(NCPU_AW-2) bits;
  - FSM state encodings RUN=1'b0, FLUSH=1'b1.
- One natural sub-module: ncpu32k_bru_fifo, a generic synchronous FIFO with wrap-bit pointers and a synchronous clear input.

Test Plan:
- Push pc=0x100, pred_taken=0; resolve taken=0 -> next cycle bpu_wb=1, bpu_wb_insn_pc=0x100, bpu_wb_taken=0; flush_req stays 0.
- Push pc=0x200, pred_taken=1, tgt=0x300; resolve taken=1, tgt=0x340 -> next cycle flush_req=1, flush_tgt=0x340, bpu_wb=1; push_ready=0 that cycle; q_empty=1 afterwards.
- Push pc=0x400, pred_taken=1; resolve taken=0 -> flush_tgt=0x401. Push pc=0x3FFFFFFF (NCPU_AW=32, PC width 30), pred_taken=1; resolve taken=0 -> flush_tgt=0x0 (wrap).
- Push 4 records with DEPTH_LOG2=2 -> push_ready=0. Push and resolve in the same cycle while full -> resolve accepted, push not accepted, count=3. Then drain all 4 in order with no mispredicts -> 4 bpu_wb pulses in FIFO order.
- Empty queue, rsv_valid=1 with push_valid=1 -> rsv_ready=0. The next cycle the resolve is accepted against the pushed entry.
- With 3 entries, flush_all=1 together with a correct resolve -> bpu_wb=1 next cycle, q_empty=1, flush_req=0. Assert rst mid-stream -> q_empty=1 and bpu_wb=0 immediately.
